if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port redirect  input  1  branch/jump taken; load redirect_pc.
REQ-005 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-006 SHALL have port halt  input  1  suppress new fetches while high.
REQ-007 SHALL have port rom_addr  output  32  byte address to the instruction ROM; equals current PC.
REQ-008 SHALL have port rom_inst  input  32  ROM word for rom_addr, combinational, same cycle.
REQ-009 SHALL have port id_inst  output  32  registered instruction to decode.
REQ-010 SHALL have port id_pc  output  32  byte address of id_inst.
REQ-011 SHALL have port id_pc4  output  32  id_pc + 4, modulo 2^32.
REQ-012 SHALL have port id_valid  output  1  id_inst/id_pc hold a live instruction.
REQ-013 SHALL have port id_ready  input  1  decode accepts the IF/ID entry this cycle.
REQ-014 SHALL have port fetch_count  output  32  number of completed IF/ID handshakes.

Function
REQ-015 SHALL compute handshake as hs = id_valid & id_ready.
REQ-016 SHALL compute load = ~halt & (~id_valid | id_ready) as the IF/ID refill condition.
REQ-017 SHALL, on a clock edge with redirect=1 and rst=0, set pc to {redirect_pc[31:2],2'b00} and id_valid to 0, regardless of halt, id_ready or load; id_inst/id_pc hold.
REQ-018 SHALL, on a clock edge with redirect=0 and load=1, capture id_inst<=rom_inst and id_pc<=pc, set id_valid<=1, and set pc<=pc+4.
REQ-019 SHALL, on a clock edge with redirect=0, load=0 and hs=1 (halt high), clear id_valid and hold pc.
REQ-020 SHALL, on a clock edge with redirect=0, load=0 and hs=0, hold pc, id_inst, id_pc and id_valid unchanged.
REQ-021 SHALL give one-cycle latency: the word at rom_addr during cycle N appears on id_inst in cycle N+1.
REQ-022 SHALL sustain one instruction per cycle when id_ready=1 and halt=0.
REQ-023 SHALL wrap pc from 32'hFFFFFFFC to 32'h00000000 without error.
REQ-024 SHALL drive rom_addr[1:0] always 2'b00; redirect_pc[1:0] are ignored.
REQ-025 SHALL increment fetch_count by 1 on every clock edge with hs=1, including the redirect edge, wrapping at 2^32.
REQ-026 SHALL count an entry consumed on the same edge as a redirect flush exactly once; the flushed refill is not counted.
REQ-027 SHALL drive id_pc4 combinationally from id_pc.

Reset
REQ-028 SHALL, on a clock edge with rst=1, set pc=RESET_PC, id_valid=0, id_inst=0, id_pc=0, fetch_count=0, overriding redirect, halt and id_ready.
REQ-029 SHALL, on the first edge after rst falls (halt=0), load the word at RESET_PC with id_valid=1.
REQ-030 SHALL, on rst asserted mid-stream, discard the pending IF/ID entry without counting it.

Verification
REQ-031 SHALL verify: reset, then id_ready=1, ROM word k = 32'h1000_0000+k -> id_pc 0,4,8,... on consecutive cycles; id_inst 32'h1000_0000,32'h1000_0001,...; fetch_count increments by 1 each cycle.
REQ-032 SHALL verify: id_ready=0 for 3 cycles with id_pc=8 -> id_inst, id_pc=8 and id_valid=1 held; rom_addr=12 held; fetch_count unchanged.
REQ-033 SHALL verify: redirect=1 with redirect_pc=32'h0000_0043 while id_valid=1 and id_ready=0 -> next cycle id_valid=0 and rom_addr=32'h0000_0040; the following cycle id_pc=32'h40.
REQ-034 SHALL verify: redirect, halt=1 and id_ready=0 all together -> redirect wins; pc=target; id_valid=0.
REQ-035 SHALL verify: pc=32'hFFFF_FFFC, fetch -> id_pc=32'hFFFF_FFFC, id_pc4=0, next rom_addr=0.
REQ-036 SHALL verify: halt=1 with id_valid=1 and id_ready=1 -> entry consumed, fetch_count+1, id_valid=0 next cycle, pc frozen until halt falls; rst mid-stream -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, ROM addressing and the IF/ID
// pipeline register with valid/ready handshake and a fetch counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] ALIGN    = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_RESET = RESET_PC & ALIGN;

  logic [31:0] pc;
  logic [31:0] pc_tgt;
  if_id_t      ifid;
  logic        hs;
  logic        load;

  assign hs     = ifid.valid & id_ready;
  assign load   = ~halt & (~ifid.valid | id_ready);
  assign pc_tgt = redirect_pc & ALIGN;

  assign rom_addr = pc;
  assign id_inst  = ifid.inst;
  assign id_pc    = ifid.pc;
  assign id_valid = ifid.valid;
  assign id_pc4   = ifid.pc + 32'd4;

  // PC and IF/ID register: redirect flushes, load refills, consume drains
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= PC_RESET;
      ifid.inst  <= '0;
      ifid.pc    <= '0;
      ifid.valid <= 1'b0;
    end else if (redirect) begin
      pc         <= pc_tgt;
      ifid.valid <= 1'b0;
    end else if (load) begin
      ifid.inst  <= rom_inst;
      ifid.pc    <= pc;
      ifid.valid <= 1'b1;
      pc         <= pc + 32'd4;
    end else if (hs) begin
      ifid.valid <= 1'b0;
    end
  end

  // Count every handshake, including the one on a redirect edge
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (hs) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic [31:0] m_cnt;

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt),
    .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_valid(id_valid), .id_ready(id_ready),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign rom_inst = rom_word(rom_addr);

  // one clock; the model decides what the entry should be from the rules
  task automatic tick();
    logic hs;
    logic ld;
    logic [31:0] w;
    hs = m_valid & id_ready;
    ld = ~halt & (~m_valid | id_ready);
    w  = rom_word(m_pc);
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_valid = 0; m_inst = 0; m_ipc = 0; m_cnt = 0;
    end else begin
      if (hs) m_cnt = m_cnt + 1;
      if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_valid = 0;
      end else if (ld) begin
        m_inst = w; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      end else if (hs) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; redirect = 1; redirect_pc = 32'h80; halt = 1; id_ready = 1;
    tick(); tick();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b want 0", id_valid);
    end
    checks++;
    if (id_inst !== 32'h0 || id_pc !== 32'h0) begin
      errors++; $display("FAIL reset_entry got %h/%h want 0/0", id_inst, id_pc);
    end
    checks++;
    if (fetch_count !== 32'h0) begin
      errors++; $display("FAIL reset_count got %0d want 0", fetch_count);
    end
    checks++;
    if (rom_addr !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h want 0", rom_addr);
    end
  endtask

  task automatic test_stream();
    rst = 0; redirect = 0; halt = 0; id_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k)
          || id_inst !== 32'h1000_0000 + 32'(k)) begin
        errors++;
        $display("FAIL stream_%0d got v%0b pc %h inst %h want pc %h",
                 k, id_valid, id_pc, id_inst, 4 * k);
      end
      checks++;
      if (fetch_count !== 32'(k)) begin
        errors++;
        $display("FAIL stream_cnt_%0d got %0d want %0d", k, fetch_count, k);
      end
    end
  endtask

  task automatic test_stall();
    id_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h8
          || id_inst !== 32'h1000_0002 || rom_addr !== 32'hC
          || fetch_count !== 32'd2) begin
        errors++;
        $display("FAIL stall_%0d got v%0b pc %h inst %h addr %h cnt %0d",
                 k, id_valid, id_pc, id_inst, rom_addr, fetch_count);
      end
    end
  endtask

  task automatic test_redirect();
    id_ready = 0; redirect = 1; redirect_pc = 32'h0000_0043;
    tick();
    redirect = 0;
    checks++;
    if (id_valid !== 1'b0 || rom_addr !== 32'h40) begin
      errors++;
      $display("FAIL redirect got v%0b addr %h want v0 addr 40",
               id_valid, rom_addr);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== 32'h1000_0010) begin
      errors++;
      $display("FAIL redirect_fetch got v%0b pc %h inst %h want pc 40",
               id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_redirect_halt();
    logic [31:0] c0;
    c0 = fetch_count;
    id_ready = 0; halt = 1; redirect = 1; redirect_pc = 32'h200;
    tick();
    redirect = 0;
    checks++;
    if (id_valid !== 1'b0 || rom_addr !== 32'h200 || fetch_count !== c0) begin
      errors++;
      $display("FAIL redir_halt got v%0b addr %h cnt %0d want v0 addr 200",
               id_valid, rom_addr, fetch_count);
    end
    tick();
    checks++;
    if (id_valid !== 1'b0 || rom_addr !== 32'h200) begin
      errors++;
      $display("FAIL halt_freeze got v%0b addr %h", id_valid, rom_addr);
    end
    halt = 0; tick();
    checks++;
    if (id_pc !== 32'h200 || id_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_release got pc %h v%0b want 200", id_pc, id_valid);
    end
  endtask

  task automatic test_redirect_count();
    logic [31:0] c0;
    c0 = fetch_count;
    id_ready = 1; redirect = 1; redirect_pc = 32'h300;
    tick();
    redirect = 0; id_ready = 0;
    checks++;
    if (fetch_count !== c0 + 1 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_count got %0d v%0b want %0d v0",
               fetch_count, id_valid, c0 + 1);
    end
    tick(); tick();
    checks++;
    if (fetch_count !== c0 + 1 || id_pc !== 32'h300) begin
      errors++;
      $display("FAIL redir_refill got cnt %0d pc %h want %0d pc 300",
               fetch_count, id_pc, c0 + 1);
    end
  endtask

  task automatic test_wrap();
    id_ready = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 0;
    tick();
    checks++;
    if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0
        || rom_addr !== 32'h0 || id_inst !== 32'h4FFF_FFFF) begin
      errors++;
      $display("FAIL wrap got pc %h pc4 %h addr %h inst %h",
               id_pc, id_pc4, rom_addr, id_inst);
    end
    tick();
    checks++;
    if (id_pc !== 32'h0 || id_pc4 !== 32'h4) begin
      errors++;
      $display("FAIL wrap_next got pc %h pc4 %h want 0/4", id_pc, id_pc4);
    end
  endtask

  task automatic test_halt();
    logic [31:0] c0;
    logic [31:0] a0;
    c0 = fetch_count; a0 = rom_addr;
    id_ready = 1; halt = 1;
    tick();
    checks++;
    if (id_valid !== 1'b0 || fetch_count !== c0 + 1 || rom_addr !== a0) begin
      errors++;
      $display("FAIL halt_consume got v%0b cnt %0d addr %h want cnt %0d addr %h",
               id_valid, fetch_count, rom_addr, c0 + 1, a0);
    end
    tick(); tick();
    checks++;
    if (id_valid !== 1'b0 || fetch_count !== c0 + 1 || rom_addr !== a0) begin
      errors++;
      $display("FAIL halt_hold got v%0b cnt %0d addr %h", id_valid,
               fetch_count, rom_addr);
    end
    halt = 0; tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== a0 || rom_addr !== a0 + 4) begin
      errors++;
      $display("FAIL halt_resume got v%0b pc %h want pc %h", id_valid,
               id_pc, a0);
    end
  endtask

  task automatic test_reset_mid();
    id_ready = 0; halt = 0;
    tick();
    rst = 1; redirect = 1; redirect_pc = 32'h500; id_ready = 1;
    tick();
    rst = 0; redirect = 0;
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0
        || fetch_count !== 32'h0 || rom_addr !== 32'h0 || id_pc4 !== 32'h4) begin
      errors++;
      $display("FAIL reset_mid got v%0b inst %h pc %h cnt %0d addr %h",
               id_valid, id_inst, id_pc, fetch_count, rom_addr);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_inst !== 32'h1000_0000 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_first got v%0b inst %h pc %h", id_valid,
               id_inst, id_pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) < 2);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = $urandom();
      if ($urandom_range(0, 3) == 0) redirect_pc[31:8] = 24'hFFFFFF;
      halt        = ($urandom_range(0, 99) < 15);
      id_ready    = ($urandom_range(0, 99) < 70);
      tick();
      checks++;
      if (rom_addr !== m_pc) begin
        errors++;
        $display("FAIL rnd_addr_%0d got %h want %h", i, rom_addr, m_pc);
      end
      checks++;
      if (id_valid !== m_valid) begin
        errors++;
        $display("FAIL rnd_valid_%0d got %0b want %0b", i, id_valid, m_valid);
      end
      checks++;
      if (id_inst !== m_inst || id_pc !== m_ipc || id_pc4 !== m_ipc + 4) begin
        errors++;
        $display("FAIL rnd_entry_%0d got %h/%h/%h want %h/%h/%h", i,
                 id_inst, id_pc, id_pc4, m_inst, m_ipc, m_ipc + 4);
      end
      checks++;
      if (fetch_count !== m_cnt) begin
        errors++;
        $display("FAIL rnd_cnt_%0d got %0d want %0d", i, fetch_count, m_cnt);
      end
    end
    rst = 0; redirect = 0; halt = 0;
  endtask

  initial begin
    m_pc = 0; m_valid = 0; m_inst = 0; m_ipc = 0; m_cnt = 0;
    rst = 1; redirect = 0; redirect_pc = 0; halt = 0; id_ready = 0;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_halt();
    test_redirect_count();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
